// File: rtl/hack_cpu_core.sv
// ============================================================================
// Module   : hack_cpu_core (with hack_alu)
// Brief    : Multi-cycle Hack CPU core, 3 clocks per instruction, sync ROM/RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hack_alu (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_zx,
    input  logic        i_nx,
    input  logic        i_zy,
    input  logic        i_ny,
    input  logic        i_f,
    input  logic        i_no,
    output logic [15:0] o_out,
    output logic        o_zr,
    output logic        o_ng
);
    logic [15:0] w_x0;
    logic [15:0] w_x1;
    logic [15:0] w_y0;
    logic [15:0] w_y1;
    logic [15:0] w_f;

    assign w_x0  = i_zx ? 16'h0000 : i_x;
    assign w_x1  = i_nx ? ~w_x0 : w_x0;
    assign w_y0  = i_zy ? 16'h0000 : i_y;
    assign w_y1  = i_ny ? ~w_y0 : w_y0;
    assign w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out = i_no ? ~w_f : w_f;
    assign o_zr  = (o_out == 16'h0000);
    assign o_ng  = o_out[15];
endmodule

module hack_cpu_core #(
    parameter int          PC_WIDTH = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic [15:0]         rom_data,
    output logic [14:0]         mem_addr,
    input  logic [15:0]         mem_rdata,
    output logic [15:0]         mem_wdata,
    output logic                mem_we,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retired
);
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_a;
    logic [15:0]         r_d;
    logic [15:0]         r_ir;

    logic [15:0]         w_y;
    logic [15:0]         w_out;
    logic                w_zr;
    logic                w_ng;
    logic                w_is_c;
    logic                w_exec;
    logic                w_take;
    logic [PC_WIDTH-1:0] w_pc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (run) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // ALU controls follow IR in every state; only the EXEC result is consumed.
    hack_alu u_alu (
        .i_x   (r_d),
        .i_y   (w_y),
        .i_zx  (r_ir[11]),
        .i_nx  (r_ir[10]),
        .i_zy  (r_ir[9]),
        .i_ny  (r_ir[8]),
        .i_f   (r_ir[7]),
        .i_no  (r_ir[6]),
        .o_out (w_out),
        .o_zr  (w_zr),
        .o_ng  (w_ng)
    );

    assign w_y      = r_ir[12] ? mem_rdata : r_a;
    assign w_is_c   = r_ir[15];
    assign w_exec   = (r_state == S_EXEC) && !reset;
    assign w_take   = (r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_zr & ~w_ng);
    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    // Jump target and memory address both use A as it was before this instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_WIDTH'(RESET_PC);
            r_a  <= 16'h0000;
            r_d  <= 16'h0000;
            r_ir <= 16'h0000;
        end else begin
            if (r_state == S_DECODE) begin
                r_ir <= rom_data;
            end
            if (r_state == S_EXEC) begin
                if (!w_is_c) begin
                    r_a  <= {1'b0, r_ir[14:0]};
                    r_pc <= w_pc_inc;
                end else begin
                    if (r_ir[5]) r_a <= w_out;
                    if (r_ir[4]) r_d <= w_out;
                    r_pc <= w_take ? r_a[PC_WIDTH-1:0] : w_pc_inc;
                end
            end
        end
    end

    assign rom_addr  = r_pc;
    assign pc        = r_pc;
    assign mem_addr  = r_a[14:0];
    assign mem_wdata = w_out;
    assign mem_we    = w_exec & w_is_c & r_ir[3];
    assign retired   = w_exec;
endmodule

`default_nettype wire

// File: tb/tb_hack_cpu_core.sv
// ============================================================================
// Module   : tb_hack_cpu_core
// Brief    : Directed + randomized bench against an instruction-level Hack model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hack_cpu_core;
    localparam int PC_W = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic [PC_W-1:0] rom_addr;
    logic [15:0]     rom_data;
    logic [14:0]     mem_addr;
    logic [15:0]     mem_rdata;
    logic [15:0]     mem_wdata;
    logic            mem_we;
    logic [PC_W-1:0] pc;
    logic            retired;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] rom    [0:32767];
    logic [15:0] dmem   [0:32767];
    logic [15:0] m_dmem [0:32767];

    logic [PC_W-1:0] mpc;
    logic [15:0]     mA;
    logic [15:0]     mD;
    logic [15:0]     m_ir;
    int              m_phase = 0;
    logic            m_valid = 1'b0;

    always #5 clk = ~clk;

    hack_cpu_core #(.PC_WIDTH(PC_W), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .pc        (pc),
        .retired   (retired)
    );

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        mem_rdata <= dmem[mem_addr];
        if (mem_we) dmem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Semantic meaning of each Hack comp mnemonic; Y is A or M depending on the a-bit.
    function automatic logic [15:0] f_comp(input logic [15:0] ir, input logic [15:0] d,
                                           input logic [15:0] a, input logic [15:0] m);
        logic [15:0] y;
        y = ir[12] ? m : a;
        case (ir[11:6])
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - d;
            6'b110011: return 16'd0 - y;
            6'b011111: return d + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return d - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return d + y;
            6'b010011: return d - y;
            6'b000111: return y - d;
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'hDEAD;
        endcase
    endfunction

    function automatic logic f_take(input logic [2:0] j, input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (j[2] && s < 0) || (j[1] && s == 0) || (j[0] && s > 0);
    endfunction

    function automatic logic [5:0] f_pick(input int i);
        case (i)
            0: return 6'b101010;  1: return 6'b111111;  2: return 6'b111010;
            3: return 6'b001100;  4: return 6'b110000;  5: return 6'b001101;
            6: return 6'b110001;  7: return 6'b001111;  8: return 6'b110011;
            9: return 6'b011111; 10: return 6'b110111; 11: return 6'b001110;
           12: return 6'b110010; 13: return 6'b000010; 14: return 6'b010011;
           15: return 6'b000111; 16: return 6'b000000; default: return 6'b010101;
        endcase
    endfunction

    function automatic logic [15:0] f_rand_instr();
        logic [2:0] j;
        if ($urandom_range(1, 0) == 1) return {1'b0, 15'($urandom)};
        j = ($urandom_range(2, 0) == 0) ? 3'($urandom) : 3'b000;
        return {1'b1, 2'($urandom), 1'($urandom), f_pick(int'($urandom_range(17, 0))),
                3'($urandom), j};
    endfunction

    // Instruction-level reference: one instruction every fetch/decode/execute triple.
    initial begin
        logic [15:0]     v_out;
        logic [PC_W-1:0] v_pc;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0; mpc = '0; mA = '0; mD = '0; m_ir = '0; m_valid = 1'b1;
            end else if (m_valid) begin
                if (m_phase == 0) begin
                    if (run) m_phase = 1;
                end else if (m_phase == 1) begin
                    m_ir = rom[mpc]; m_phase = 2;
                end else begin
                    if (!m_ir[15]) begin
                        mA  = {1'b0, m_ir[14:0]};
                        mpc = mpc + 1'b1;
                    end else begin
                        v_out = f_comp(m_ir, mD, mA, m_dmem[mA[14:0]]);
                        v_pc  = f_take(m_ir[2:0], v_out) ? mA[PC_W-1:0] : mpc + 1'b1;
                        if (m_ir[3]) m_dmem[mA[14:0]] = v_out;
                        if (m_ir[5]) mA = v_out;
                        if (m_ir[4]) mD = v_out;
                        mpc = v_pc;
                    end
                    m_phase = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_ex;
        logic exp_we;
        if (m_valid) begin
            exp_ex = (m_phase == 2) && !reset;
            exp_we = exp_ex && m_ir[15] && m_ir[3];
            chk("pc", 32'(pc), 32'(mpc));
            chk("rom_addr", 32'(rom_addr), 32'(mpc));
            chk("mem_addr", 32'(mem_addr), 32'(mA[14:0]));
            chk("retired", 32'(retired), 32'(exp_ex));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we)
                chk("mem_wdata", 32'(mem_wdata), 32'(f_comp(m_ir, mD, mA, m_dmem[mA[14:0]])));
        end
    end

    task automatic wait_retire(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 200) begin
            @(negedge clk); cyc++;
            if (retired) seen++;
        end
        chk("retire_wait", 32'(seen), 32'(n));
    endtask

    task automatic wait_we();
        int cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (!mem_we && cyc < 100);
        chk("we_wait", 32'(mem_we), 32'd1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 32768; i++) begin
            rom[i]    = f_rand_instr();
            dmem[i]   = 16'($urandom);
            m_dmem[i] = dmem[i];
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        reset = 1'b1; run = 1'b0;
        clear_all();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE090;
        rom[4] = 16'h0064; rom[5] = 16'hE308; rom[6] = 16'h7FFF; rom[7] = 16'hEA87;
        rom[32767] = 16'h0009;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1 reset = 1'b0; run = 1'b1;

        wait_retire(1);
        @(negedge clk);
        chk("a_instr_pc", 32'(pc), 32'd1);
        chk("a_instr_A", 32'(mem_addr), 32'd5);
        wait_we();
        chk("store_addr", 32'(mem_addr), 32'd100);
        chk("store_data", 32'(mem_wdata), 32'h000C);
        @(negedge clk);
        chk("store_single", 32'(mem_we), 32'd0);
        cyc = 0;
        while (pc != 15'h7FFF && cyc < 50) begin @(negedge clk); cyc++; end
        chk("jmp_to_top", 32'(pc), 32'h7FFF);
        wait_retire(1);
        @(negedge clk);
        chk("pc_wrap", 32'(pc), 32'd0);
        chk("wrap_A", 32'(mem_addr), 32'd9);
        run = 1'b0; cnt = 0;
        repeat (9) begin @(negedge clk); if (retired) cnt++; end
        chk("hold_pc", 32'(pc), 32'd0);
        chk("hold_retired", 32'(cnt), 32'd0);

        reset = 1'b1;
        @(posedge clk); #1;
        rom[0] = 16'h0009; rom[1] = 16'hFDEF; rom[9] = 16'hEE90; rom[10] = 16'h0003;
        rom[11] = 16'hE304; rom[3] = 16'hEA90; rom[4] = 16'hE304; rom[5] = 16'hE302;
        dmem[9] = 16'd4; m_dmem[9] = 16'd4; run = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        wait_we();
        chk("am_addr", 32'(mem_addr), 32'd9);
        chk("am_data", 32'(mem_wdata), 32'd5);
        @(negedge clk);
        chk("am_jmp_pc", 32'(pc), 32'd9);
        chk("am_newA", 32'(mem_addr), 32'd5);
        wait_retire(3);
        @(negedge clk);
        chk("jlt_taken", 32'(pc), 32'd3);
        wait_retire(2);
        @(negedge clk);
        chk("jlt_not_taken", 32'(pc), 32'd5);
        wait_retire(1);
        @(negedge clk);
        chk("jeq_taken", 32'(pc), 32'd3);
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_exec_retired", 32'(retired), 32'd0);
        chk("rst_exec_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_decode_pc", 32'(pc), 32'd0);

        reset = 1'b1;
        @(posedge clk); #1;
        clear_all();
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            run   = ($urandom_range(9, 0) != 0);
            reset = ($urandom_range(149, 0) == 0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
